// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock ratio detector.
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int LOCK_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ratio_detector_if.sv
// Divided clock under test plus the measurement results reported back.
interface clk_div_ratio_detector_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             div_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             duty_err;
    logic             locked;
    logic             timeout;

    modport master (
        output div_in,
        input  period_out, high_out, period_valid, duty_err, locked, timeout
    );

    modport slave (
        input  div_in,
        output period_out, high_out, period_valid, duty_err, locked, timeout
    );

endinterface

// File: rtl/clk_div_edge_det.sv
// Registers a same-domain signal and flags its rising and falling edges.
module clk_div_edge_det
    import clk_div_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    // Previous-cycle copy of d; a high d right after reset reads as a rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/clk_div_ratio_detector.sv
// Measures period, high time, duty balance and lock of a clk-synchronous divided clock.
module clk_div_ratio_detector
    import clk_div_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LOCK_COUNT = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    clk_div_ratio_detector_if.slave  bus
);

    localparam int                 MATCH_W   = LOCK_W + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [MATCH_W-1:0] MATCH_MAX = {MATCH_W{1'b1}};
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1'b1);
    localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_COUNT + 1);

    state_e               state_r, state_nxt_s;
    logic                 div_q_s, rise_s, unused_fall_s;
    logic [CNT_W-1:0]     per_cnt_r, hi_cnt_r, ref_per_r;
    logic [MATCH_W-1:0]   match_cnt_r, match_nxt_s;
    logic [CNT_W-1:0]     period_out_r, high_out_r;
    logic                 period_valid_r, duty_err_r, locked_r, timeout_r;
    logic                 active_s, sat_s, meas_s, same_s, lock_hit_s, duty_s;
    logic [CNT_W:0]       hi_x2_s;

    clk_div_edge_det u_edge (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.div_in),
        .q      (div_q_s),
        .rise   (rise_s),
        .fall   (unused_fall_s)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Measurement qualifiers, lock run length and next state.
    always_comb begin
        active_s    = (state_r != IDLE);
        sat_s       = active_s && (per_cnt_r == CNT_MAX);
        meas_s      = active_s && rise_s && !sat_s;
        same_s      = (per_cnt_r == ref_per_r);
        hi_x2_s     = {hi_cnt_r, 1'b0};
        duty_s      = (hi_x2_s != {1'b0, per_cnt_r});
        if (!same_s) begin
            match_nxt_s = MATCH_ONE;
        end else if (match_cnt_r == MATCH_MAX) begin
            match_nxt_s = match_cnt_r;
        end else begin
            match_nxt_s = match_cnt_r + MATCH_ONE;
        end
        // The reference period itself counts as one of the identical periods.
        lock_hit_s  = (match_nxt_s >= LOCK_TGT);
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) state_nxt_s = MEAS;
                else        state_nxt_s = IDLE;
            end
            MEAS: begin
                if (sat_s)                     state_nxt_s = IDLE;
                else if (meas_s && lock_hit_s) state_nxt_s = LOCKED;
                else                           state_nxt_s = MEAS;
            end
            LOCKED: begin
                if (sat_s)                 state_nxt_s = IDLE;
                else if (meas_s && !same_s) state_nxt_s = MEAS;
                else                       state_nxt_s = LOCKED;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Period and high-time counters, restarted on every rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            per_cnt_r <= CNT_ZERO;
            hi_cnt_r  <= CNT_ZERO;
        end else if (rise_s) begin
            per_cnt_r <= CNT_ONE;
            hi_cnt_r  <= CNT_ONE;
        end else begin
            if (per_cnt_r != CNT_MAX) per_cnt_r <= per_cnt_r + CNT_ONE;
            if (bus.div_in && (hi_cnt_r != CNT_MAX)) hi_cnt_r <= hi_cnt_r + CNT_ONE;
        end
    end

    // Result registers, lock reference and sticky timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_out_r   <= CNT_ZERO;
            high_out_r     <= CNT_ZERO;
            period_valid_r <= 1'b0;
            duty_err_r     <= 1'b0;
            locked_r       <= 1'b0;
            timeout_r      <= 1'b0;
            ref_per_r      <= CNT_ZERO;
            match_cnt_r    <= {MATCH_W{1'b0}};
        end else begin
            period_valid_r <= meas_s;
            locked_r       <= (state_nxt_s == LOCKED);
            if (meas_s) begin
                period_out_r <= per_cnt_r;
                high_out_r   <= hi_cnt_r;
                duty_err_r   <= duty_s;
                ref_per_r    <= per_cnt_r;
                match_cnt_r  <= match_nxt_s;
            end else if ((state_r == IDLE) && rise_s) begin
                // A fresh start must not compare against a pre-timeout period.
                ref_per_r    <= CNT_ZERO;
                match_cnt_r  <= {MATCH_W{1'b0}};
            end
            if (sat_s)       timeout_r <= 1'b1;
            else if (meas_s) timeout_r <= 1'b0;
        end
    end

    assign bus.period_out   = period_out_r;
    assign bus.high_out     = high_out_r;
    assign bus.period_valid = period_valid_r;
    assign bus.duty_err     = duty_err_r;
    assign bus.locked       = locked_r;
    assign bus.timeout      = timeout_r;

endmodule
